// File: rtl/seven_seg_monitor.sv
// Seven-segment receive monitor: qualifies a stable segment pattern, decodes it
// to a digit / dash / bad flag, and offers it as a valid/ready record.
module seven_seg_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       seg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_digit,
  output logic             out_dash,
  output logic             out_bad,
  output logic [6:0]       out_raw,
  output logic             overrun,
  output logic [CNT_W-1:0] update_count
);

  // Handshake: a record is transferred on any edge where out_valid && out_ready.
  // While out_valid is high and out_ready is low the record fields stay frozen
  // unless a newer pattern commits, which replaces it and sets the sticky overrun.

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  localparam logic [6:0] PAT_BLANK = 7'b0000000;
  localparam logic [6:0] PAT_DASH  = 7'b0000001;

  logic [6:0]    s;
  logic [CW-1:0] cnt;
  logic [6:0]    committed;

  logic          same;
  logic          commit;
  logic          report;
  logic          accept;
  logic [4:0]    dec_digit;
  logic          dec_dash;
  logic          dec_bad;

  assign same   = (seg == s);
  assign commit = same && (cnt == CNT_LAST) && (s != committed);
  // Blank is committed silently so the next real glyph is reported again.
  assign report = commit && (s != PAT_BLANK);
  assign accept = out_valid && out_ready;

  always_comb begin
    dec_digit = 5'd0;
    dec_dash  = 1'b0;
    dec_bad   = 1'b0;
    case (s)
      7'b1111110: dec_digit = 5'd0;
      7'b0110000: dec_digit = 5'd1;
      7'b1101101: dec_digit = 5'd2;
      7'b1111001: dec_digit = 5'd3;
      7'b0110011: dec_digit = 5'd4;
      7'b1011011: dec_digit = 5'd5;
      7'b1011111: dec_digit = 5'd6;
      7'b1110000: dec_digit = 5'd7;
      7'b1111111: dec_digit = 5'd8;
      7'b1111011: dec_digit = 5'd9;
      PAT_DASH:   dec_dash  = 1'b1;
      default:    dec_bad   = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s            <= '0;
      cnt          <= '0;
      committed    <= PAT_BLANK;
      out_valid    <= 1'b0;
      out_digit    <= '0;
      out_dash     <= 1'b0;
      out_bad      <= 1'b0;
      out_raw      <= '0;
      overrun      <= 1'b0;
      update_count <= '0;
    end else begin
      s <= seg;
      if (!same)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + 1'b1;

      if (commit)
        committed <= s;

      if (report) begin
        out_valid    <= 1'b1;
        out_digit    <= dec_digit;
        out_dash     <= dec_dash;
        out_bad      <= dec_bad;
        out_raw      <= s;
        update_count <= update_count + 1'b1;
        if (out_valid && !out_ready)
          overrun <= 1'b1;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_monitor.sv
// Directed bench for seven_seg_monitor: one task per scenario, inline checks.
module tb_seven_seg_monitor;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, out_ready, out_valid, out_dash, out_bad, overrun;
  logic [6:0] seg, out_raw;
  logic [4:0] out_digit;
  logic [7:0] update_count;

  logic       rst2_n, ready2, valid2, dash2, bad2, overrun2;
  logic [6:0] seg2, raw2;
  logic [4:0] digit2;
  logic [1:0] count2;

  seven_seg_monitor #(.STABLE_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .seg(seg), .out_valid(out_valid),
    .out_ready(out_ready), .out_digit(out_digit), .out_dash(out_dash),
    .out_bad(out_bad), .out_raw(out_raw), .overrun(overrun),
    .update_count(update_count)
  );

  seven_seg_monitor #(.STABLE_CYCLES(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .seg(seg2), .out_valid(valid2),
    .out_ready(ready2), .out_digit(digit2), .out_dash(dash2),
    .out_bad(bad2), .out_raw(raw2), .overrun(overrun2),
    .update_count(count2)
  );

  int checks = 0;
  int errors = 0;

  logic [6:0] pat [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                           7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

  int         pulses;
  logic [4:0] rec_digit;
  logic       rec_dash, rec_bad;
  logic [6:0] rec_raw;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a pattern for n edges and remember the last record seen valid.
  task automatic hold(input logic [6:0] p, input int n);
    seg = p;
    for (int i = 0; i < n; i++) begin
      step();
      if (out_valid) begin
        pulses++;
        rec_digit = out_digit;
        rec_dash  = out_dash;
        rec_bad   = out_bad;
        rec_raw   = out_raw;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    seg   = 7'h00;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b0; seg = 7'h7F;
    rst2_n = 1'b0; ready2 = 1'b1; seg2 = 7'h00;
    step();
    step();
    checks++;
    if ({out_valid, out_digit, out_dash, out_bad, out_raw, overrun, update_count} !== 24'd0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b d=%0d dash=%0b bad=%0b raw=%h ovr=%0b cnt=%0d, want all 0",
               out_valid, out_digit, out_dash, out_bad, out_raw, overrun, update_count);
    end
    checks++;
    if ({valid2, count2, overrun2} !== 4'd0) begin
      errors++;
      $display("FAIL reset_dut2: got v=%0b cnt=%0d ovr=%0b, want 0", valid2, count2, overrun2);
    end
    rst_n = 1'b1; rst2_n = 1'b1; seg = 7'h00;
  endtask

  task automatic test_first_record();
    do_reset();
    out_ready = 1'b1;
    seg = 7'h7E;
    for (int i = 1; i <= 10; i++) begin
      step();
      checks++;
      if (out_valid !== (i == 5)) begin
        errors++;
        $display("FAIL first_valid_edge%0d: got %0b want %0b", i, out_valid, (i == 5));
      end
      if (i == 5) begin
        checks++;
        if (out_digit !== 5'd0 || out_raw !== 7'h7E || update_count !== 8'd1 || out_dash !== 1'b0 || out_bad !== 1'b0) begin
          errors++;
          $display("FAIL first_record: got d=%0d raw=%h cnt=%0d dash=%0b bad=%0b, want d=0 raw=7e cnt=1",
                   out_digit, out_raw, update_count, out_dash, out_bad);
        end
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    out_ready = 1'b1;
    pulses = 0;
    hold(7'h30, 2);
    hold(7'h6D, 8);
    checks++;
    if (pulses !== 1 || rec_digit !== 5'd2 || update_count !== 8'd1) begin
      errors++;
      $display("FAIL glitch_reject: got pulses=%0d d=%0d cnt=%0d, want pulses=1 d=2 cnt=1",
               pulses, rec_digit, update_count);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    out_ready = 1'b0;
    hold(7'h79, 6);
    hold(7'h33, 6);
    checks++;
    if (out_valid !== 1'b1 || out_digit !== 5'd4 || overrun !== 1'b1 || update_count !== 8'd2) begin
      errors++;
      $display("FAIL overrun_set: got v=%0b d=%0d ovr=%0b cnt=%0d, want v=1 d=4 ovr=1 cnt=2",
               out_valid, out_digit, overrun, update_count);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_accept: got v=%0b ovr=%0b, want v=0 ovr=1", out_valid, overrun);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    out_ready = 1'b0;
    hold(7'h7F, 6);
    seg = 7'h7B;
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (out_valid !== 1'b1 || out_digit !== 5'd8) begin
      errors++;
      $display("FAIL b2b_held: got v=%0b d=%0d, want v=1 d=8", out_valid, out_digit);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_digit !== 5'd9 || overrun !== 1'b0 || update_count !== 8'd2) begin
      errors++;
      $display("FAIL b2b_commit_accept: got v=%0b d=%0d ovr=%0b cnt=%0d, want v=1 d=9 ovr=0 cnt=2",
               out_valid, out_digit, overrun, update_count);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_clear: got v=%0b want 0", out_valid);
    end
  endtask

  task automatic test_decode();
    do_reset();
    out_ready = 1'b1;
    for (int d = 0; d < 10; d++) begin
      pulses = 0;
      hold(pat[d], 6);
      checks++;
      if (pulses !== 1 || rec_digit !== 5'(d) || rec_dash !== 1'b0 || rec_bad !== 1'b0 || rec_raw !== pat[d]) begin
        errors++;
        $display("FAIL decode_%0d: got pulses=%0d d=%0d dash=%0b bad=%0b raw=%h, want 1 record d=%0d raw=%h",
                 d, pulses, rec_digit, rec_dash, rec_bad, rec_raw, d, pat[d]);
      end
    end
    pulses = 0;
    hold(7'h01, 6);
    checks++;
    if (pulses !== 1 || rec_dash !== 1'b1 || rec_bad !== 1'b0 || rec_digit !== 5'd0) begin
      errors++;
      $display("FAIL decode_dash: got pulses=%0d dash=%0b bad=%0b d=%0d, want dash=1 bad=0 d=0",
               pulses, rec_dash, rec_bad, rec_digit);
    end
    pulses = 0;
    hold(7'h55, 6);
    checks++;
    if (pulses !== 1 || rec_bad !== 1'b1 || rec_dash !== 1'b0 || rec_digit !== 5'd0 || rec_raw !== 7'h55) begin
      errors++;
      $display("FAIL decode_bad: got pulses=%0d bad=%0b dash=%0b d=%0d raw=%h, want bad=1 dash=0 d=0 raw=55",
               pulses, rec_bad, rec_dash, rec_digit, rec_raw);
    end
    checks++;
    if (update_count !== 8'd12) begin
      errors++;
      $display("FAIL decode_count: got %0d want 12", update_count);
    end
  endtask

  task automatic test_blank_and_reset();
    do_reset();
    out_ready = 1'b1;
    pulses = 0;
    hold(7'h5B, 6);
    hold(7'h00, 6);
    hold(7'h5B, 6);
    checks++;
    if (pulses !== 2 || update_count !== 8'd2 || rec_digit !== 5'd5) begin
      errors++;
      $display("FAIL blank_rearm: got pulses=%0d cnt=%0d d=%0d, want pulses=2 cnt=2 d=5",
               pulses, update_count, rec_digit);
    end
    // Interrupt a qualifying pattern with reset, then bring segments back to blank.
    hold(7'h70, 2);
    rst_n = 1'b0;
    step();
    checks++;
    if ({out_valid, out_digit, out_dash, out_bad, out_raw, overrun, update_count} !== 24'd0) begin
      errors++;
      $display("FAIL midqual_reset: got v=%0b d=%0d raw=%h ovr=%0b cnt=%0d, want all 0",
               out_valid, out_digit, out_raw, overrun, update_count);
    end
    rst_n = 1'b1;
    pulses = 0;
    hold(7'h00, 8);
    checks++;
    if (pulses !== 0 || update_count !== 8'd0) begin
      errors++;
      $display("FAIL midqual_norecord: got pulses=%0d cnt=%0d, want 0 0", pulses, update_count);
    end
    // Reset landing on the commit edge discards that commit.
    pulses = 0;
    hold(7'h5F, 4);
    rst_n = 1'b0;
    step();
    checks++;
    if (pulses !== 0 || out_valid !== 1'b0 || update_count !== 8'd0) begin
      errors++;
      $display("FAIL commit_reset: got pulses=%0d v=%0b cnt=%0d, want 0 0 0", pulses, out_valid, update_count);
    end
    rst_n = 1'b1;
    hold(7'h00, 6);
  endtask

  task automatic test_wrap();
    int exp_cnt [5] = '{1, 2, 3, 0, 1};
    for (int k = 0; k < 5; k++) begin
      seg2 = pat[k + 1];
      for (int i = 0; i < 6; i++) step();
      checks++;
      if (count2 !== 2'(exp_cnt[k])) begin
        errors++;
        $display("FAIL wrap_%0d: got cnt=%0d want %0d", k, count2, exp_cnt[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_record();
    test_glitch();
    test_overrun();
    test_back_to_back();
    test_decode();
    test_blank_and_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_monitor.md
Name: seven_seg_monitor

Overview:
- Receive side of the seven-segment interface: samples the seven segment lines (A..G), waits for a stable pattern, and decodes it back to a digit 0-9, the "-" invalid glyph, or a bad-pattern flag.
- Sits beside the display driver and watches the same segment pins. It gives the processor bench and on-board self-test a checked, handshaked record of every value the processor shows.

Parameters:
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is accepted; must be >= 1.
- CNT_W, 8, width of the update counter; wraps modulo 2^CNT_W.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- seg  input  7  segment lines; bit 6 = A, bit 5 = B, ..., bit 0 = G; 1 = lit
- out_valid  output  1  decoded record pending
- out_ready  input  1  consumer accepts record when out_valid && out_ready
- out_digit  output  5  decoded digit 0-9; 0 when out_dash or out_bad
- out_dash  output  1  record is the "-" glyph (7'b0000001)
- out_bad  output  1  record is an unrecognised pattern
- out_raw  output  7  the accepted segment pattern
- overrun  output  1  sticky: a record was overwritten before it was consumed
- update_count  output  CNT_W  number of accepted patterns, wrapping

Behaviour:
- Reset (rst_n low at an edge):
  - out_valid, out_digit, out_dash, out_bad, out_raw, overrun and update_count all go to 0.
  - Sample register s = 0, stability counter cnt = 0.
  - Committed pattern = 7'b0000000 (blank), so the first stable non-blank pattern after reset is reported.
  - Reset overrides every other event in the same cycle.
- Sampling, every edge:
  - s <= seg.
  - If seg == s: cnt <= min(cnt+1, STABLE_CYCLES); otherwise cnt <= 0.
- Commit condition (combinational, acted on at the edge): seg == s && cnt == STABLE_CYCLES-1 && s != committed.
  - Effect at the edge: committed <= s; record registers loaded; out_valid <= 1; update_count += 1.
- Latency: if pattern P is first sampled into s at edge k and held, the commit happens at edge k+STABLE_CYCLES. out_valid is visible in the following cycle.
- A glitch (any seg change) clears cnt and restarts qualification. A pattern held for fewer than STABLE_CYCLES+1 edges is never reported.
- Re-stabilising on the already-committed pattern produces no record. The blank pattern 0000000 is committed silently: no record and no count increment, but committed is updated, so a following real glyph is reported.
- Decode table (seg = ABCDEFG -> digit):
  - 1111110 -> 0
  - 0110000 -> 1
  - 1101101 -> 2
  - 1111001 -> 3
  - 0110011 -> 4
  - 1011011 -> 5
  - 1011111 -> 6
  - 1110000 -> 7
  - 1111111 -> 8
  - 1111011 -> 9
  - 0000001 -> out_dash = 1
  - anything else -> out_bad = 1
  - out_dash and out_bad are never both 1.
- Handshake:
  - The record is held stable while out_valid && !out_ready.
  - An accept (out_valid && out_ready) with no commit clears out_valid at that edge.
  - Accept and commit at the same edge: the new record loads, out_valid stays 1, no overrun.
  - Commit while out_valid && !out_ready: the new record overwrites the old one, out_valid stays 1, and overrun <= 1 (cleared only by reset).
- update_count increments once per reported commit and wraps from 2^CNT_W-1 to 0.
- A commit in the same cycle as reset is discarded.

Test Plan:
- Reset, then seg = 1111110 held 10 cycles, STABLE_CYCLES = 4, out_ready = 1 -> out_valid pulses exactly one cycle, 4 edges after the first sample edge; out_digit = 0, out_raw = 1111110, update_count = 1.
- seg = 0110000 held 2 cycles, then 1101101 held 8 cycles -> a single record out_digit = 2; no record for 1; update_count = 1.
- out_ready = 0; seg 1111001 (3) stable, then 0110011 (4) stable -> out_digit = 4, overrun = 1. Then out_ready = 1 for one cycle -> out_valid = 0 and overrun still 1.
- seg = 0000001 stable -> out_dash = 1, out_digit = 0. Then seg = 1010101 stable -> out_bad = 1, out_dash = 0.
- Sequence 5 stable, blank stable, 5 stable -> two records for 5, update_count = 2. Drive rst_n low mid-qualification -> all outputs 0 and no record from the interrupted pattern.
- CNT_W = 2; five distinct stable digits -> update_count reads 1, 2, 3, 0, 1.
